// File: rtl/proc_stim_pkg.sv
// proc_stim_pkg: shared state encodings, LFSR taps and MISR helpers for the processor stimulus engine
package proc_stim_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam int MISR_T3 = 31;
    localparam int MISR_T2 = 21;
    localparam int MISR_T1 = 1;
    localparam int MISR_T0 = 0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], s[MISR_T3] ^ s[MISR_T2] ^ s[MISR_T1] ^ s[MISR_T0]} ^ f;
    endfunction
endpackage

// File: rtl/proc_stim_lfsr32.sv
// proc_stim_lfsr32: 32-bit Galois LFSR with seed reload and advance enable
module proc_stim_lfsr32
    import proc_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] value
);
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    // Seed on reset or load, otherwise step only when asked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) value <= SEED_EFF;
        else if (load) value <= SEED_EFF;
        else if (adv) value <= lfsr_step(value);
    end
endmodule

// File: rtl/proc_stim_engine.sv
// proc_stim_engine: sequences processor reset, drives LFSR data vectors and compacts outputs into a MISR
// Optional build macro PROC_STIM_WIDE_RANDOM_EN fills every 32-bit lane of d_in with a rotated LFSR word.
module proc_stim_engine
    import proc_stim_pkg::*;
#(
    parameter int          DATA_W       = 128,
    parameter int          ADDR_W       = 16,
    parameter int          STAT_W       = 8,
    parameter int          NUM_VECTORS  = 20,
    parameter int          HOLD_CYCLES  = 2,
    parameter int          RESET_CYCLES = 2,
    parameter int          INIT_DATA    = 10,
    parameter logic [31:0] SEED         = 32'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              dut_reset,
    output logic [DATA_W-1:0] d_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [ADDR_W-1:0] address,
    input  logic              mw_en,
    input  logic [STAT_W-1:0] status,
    output logic              busy,
    output logic              done,
    output logic [15:0]       vec_count,
    output logic [15:0]       store_count,
    output logic [31:0]       signature
);
    localparam int LANES = (DATA_W + 31) / 32;
    localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_DATA);

    state_t              state, nxt;
    logic [31:0]         cnt;
    logic [31:0]         lfsr_q, lfsr_d, fold;
    logic                last, final_vec, start_acc, adv;
    logic                busy_d, done_d, dut_reset_d;
    logic [DATA_W-1:0]   d_in_d;
    logic [LANES*32-1:0] word_pad, alu_pad;

    assign last      = (state == RST) ? (cnt == 32'(RESET_CYCLES - 1)) : (cnt == 32'(HOLD_CYCLES - 1));
    assign final_vec = vec_count == 16'(NUM_VECTORS);
    assign start_acc = start && (state == IDLE || state == DONE);
    assign adv       = last && (state == RST || (state == DRIVE && !final_vec));
    assign lfsr_d    = lfsr_step(lfsr_q);

    proc_stim_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc),
        .adv   (adv),
        .value (lfsr_q)
    );

    // Build the next data word from the upcoming LFSR value
    always_comb begin
        word_pad = '0;
`ifdef PROC_STIM_WIDE_RANDOM_EN
        for (int k = 0; k < LANES; k++) word_pad[32*k +: 32] = rotl32(lfsr_d, 32'((7 * k) % 32));
`else
        word_pad[31:0] = lfsr_d;
`endif
    end

    // Fold all ALU lanes, shifted address and status into one 32-bit MISR input
    always_comb begin
        alu_pad = '0;
        alu_pad[DATA_W-1:0] = alu_out;
        fold = (32'(address) << 8) ^ 32'(status);
        for (int k = 0; k < LANES; k++) fold = fold ^ alu_pad[32*k +: 32];
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nxt;
    end

    // FSM next state: start from IDLE/DONE, leave RST and DRIVE on their final count
    always_comb begin
        nxt = start_acc                            ? RST   :
              (state == RST && last)               ? DRIVE :
              (state == DRIVE && last && final_vec) ? DONE  : state;
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        busy_d      = nxt == RST || nxt == DRIVE;
        done_d      = nxt == DONE;
        dut_reset_d = nxt == IDLE || nxt == RST;
        d_in_d      = adv ? word_pad[DATA_W-1:0] : start_acc ? INIT_WORD : d_in;
    end

    // Registered outputs, phase counter, vector/store counters and MISR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            dut_reset   <= 1'b1;
            d_in        <= INIT_WORD;
            cnt         <= '0;
            vec_count   <= '0;
            store_count <= '0;
            signature   <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            dut_reset   <= dut_reset_d;
            d_in        <= d_in_d;
            cnt         <= (start_acc || last) ? '0 : (state == RST || state == DRIVE) ? cnt + 32'd1 : cnt;
            vec_count   <= start_acc ? '0 : adv ? vec_count + 16'd1 : vec_count;
            store_count <= start_acc ? '0 :
                           (state == DRIVE && mw_en && store_count != 16'hFFFF) ? store_count + 16'd1 : store_count;
            signature   <= start_acc ? '0 : (state == DRIVE) ? misr_step(signature, fold) : signature;
        end
    end
endmodule

// File: tb/tb_proc_stim_engine.sv
// tb_proc_stim_engine: randomized run-level checks of proc_stim_engine against a behavioural model
module tb_proc_stim_engine;
    localparam int R = 2;
    localparam int H = 2;
    localparam int N = 20;
    localparam int TOTAL = R + N * H;

    logic         clk = 1'b0, reset = 1'b0, start = 1'b0, mw_en = 1'b0;
    logic [127:0] alu_out = '0;
    logic [15:0]  address = '0;
    logic [7:0]   status = '0;
    logic         dut_reset, busy, done;
    logic [127:0] d_in;
    logic [15:0]  vec_count, store_count;
    logic [31:0]  signature;

    logic         s_start = 1'b0, s_mw = 1'b0;
    logic [127:0] s_alu = '0;
    logic [15:0]  s_address = '0;
    logic [7:0]   s_status = '0;
    logic         s_dut_reset, s_busy, s_done;
    logic [127:0] s_d_in;
    logic [15:0]  s_vec_count, s_store_count;
    logic [31:0]  s_signature;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    proc_stim_engine dut (
        .clk(clk), .reset(reset), .start(start), .dut_reset(dut_reset), .d_in(d_in),
        .alu_out(alu_out), .address(address), .mw_en(mw_en), .status(status),
        .busy(busy), .done(done), .vec_count(vec_count), .store_count(store_count),
        .signature(signature)
    );

    proc_stim_engine #(.NUM_VECTORS(1), .HOLD_CYCLES(1)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .dut_reset(s_dut_reset), .d_in(s_d_in),
        .alu_out(s_alu), .address(s_address), .mw_en(s_mw), .status(s_status),
        .busy(s_busy), .done(s_done), .vec_count(s_vec_count), .store_count(s_store_count),
        .signature(s_signature)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_after(input int k);
        logic [31:0] s = 32'h1;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        return s;
    endfunction

    function automatic logic [127:0] exp_word(input int k);
        logic [31:0]  s = lfsr_after(k);
        logic [127:0] w = '0;
        logic [63:0]  t;
`ifdef PROC_STIM_WIDE_RANDOM_EN
        for (int i = 0; i < 4; i++) begin
            t = {s, s} << ((7 * i) % 32);
            w[32*i +: 32] = t[63:32];
        end
`else
        t = {32'h0, s};
        w[31:0] = t[31:0];
`endif
        return w;
    endfunction

    function automatic logic [31:0] fold_ref(input logic [127:0] a, input logic [15:0] ad, input logic [7:0] st);
        logic [31:0] f = {8'h0, ad, 8'h0} ^ {24'h0, st};
        for (int i = 0; i < 4; i++) f = f ^ a[32*i +: 32];
        return f;
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] f);
        logic fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb} ^ f;
    endfunction

    task automatic set_inputs(input int mode);
        alu_out = (mode == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
        address = (mode == 0) ? '0 : 16'($urandom);
        status  = (mode == 0) ? '0 : 8'($urandom);
        mw_en   = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : 1'($urandom % 2);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_dut_reset"}, dut_reset, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_d_in"}, d_in, 128'd10);
        chk({tag, "_vec"}, vec_count, 16'd0);
        chk({tag, "_store"}, store_count, 16'd0);
        chk({tag, "_sig"}, signature, 32'd0);
    endtask

    task automatic run(input int mode, input bit poke, input int abort_at);
        logic [31:0] sig = '0;
        int st = 0;
        int vec;
        @(negedge clk);
        start = 1'b1;
        set_inputs(mode);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= TOTAL + 2; e++) begin
            set_inputs(mode);
            start = poke && e == 10;
            @(posedge clk);
            if (e > R && e <= TOTAL) begin
                sig = misr_ref(sig, fold_ref(alu_out, address, status));
                st += int'(mw_en);
            end
            @(negedge clk);
            vec = (e < R) ? 0 : ((e - R) / H + 1 > N) ? N : (e - R) / H + 1;
            chk("dut_reset", dut_reset, e < R);
            chk("busy", busy, e < TOTAL);
            chk("done", done, e >= TOTAL);
            chk("vec_count", vec_count, 16'(vec));
            chk("d_in", d_in, (vec == 0) ? 128'd10 : exp_word(vec));
`ifndef PROC_STIM_WIDE_RANDOM_EN
            if (mode == 0 && e == R) chk("d_in_v1", d_in, 128'h80200003);
            if (mode == 0 && e == R + H) chk("d_in_v2", d_in, 128'hC0300002);
            if (mode == 0 && e == R + 2 * H) chk("d_in_v3", d_in, 128'h60180001);
`endif
            if (e == abort_at) begin
                reset = 1'b0;
                #1;
                check_idle("abort");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        chk("signature", signature, sig);
        chk("store_count", store_count, 16'(st));
        if (mode == 2) chk("store_all", store_count, 16'd40);
    endtask

    task automatic small_run(input logic [127:0] a, input logic [15:0] ad, input logic [7:0] st, input logic [31:0] exp_sig);
        @(negedge clk);
        s_start = 1'b1;
        s_alu = a;
        s_address = ad;
        s_status = st;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk("s_done", s_done, e >= 3);
        end
        chk("s_signature", s_signature, exp_sig);
        chk("s_vec_count", s_vec_count, 16'd1);
        chk("s_d_in", s_d_in, exp_word(1));
    endtask

    initial begin
        logic [127:0] a;
        logic [15:0]  ad;
        logic [7:0]   st;
        repeat (3) @(posedge clk);
        #1;
        check_idle("in_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("power_on");
        run(0, 1'b0, 0);
        run(1, 1'b1, 0);
        run(2, 1'b0, 0);
        run(1, 1'b0, R + 6 * H + 1);
        run(1, 1'b0, 0);
        small_run(128'd1, 16'd0, 8'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            a  = {$urandom, $urandom, $urandom, $urandom};
            ad = 16'($urandom);
            st = 8'($urandom);
            small_run(a, ad, st, fold_ref(a, ad, st));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/proc_stim_engine.md
Name: proc_stim_engine

Overview:
- Synthesizable, parametrised stimulus and response engine for the RISC processor core; replaces ad-hoc bench stimulus for on-FPGA self-test.
- Sequences processor reset, drives pseudo-random data words onto the processor data input for a configurable number of vectors and hold period, and compacts processor outputs into a 32-bit signature.
- Sits beside the processor top; its outputs feed the core's reset and data input, and its inputs monitor the core's outputs.

Parameters:
- DATA_W, 128, processor data/ALU width; must be a multiple of 32 or less than 32.
- ADDR_W, 16, processor address width; must be 24 or less.
- STAT_W, 8, processor status width; must be 8 or less.
- NUM_VECTORS, 20, vectors per run; must be 1 or more.
- HOLD_CYCLES, 2, clocks each vector is held; must be 1 or more.
- RESET_CYCLES, 2, clocks dut_reset is held at run start; must be 1 or more.
- INIT_DATA, 10, d_in value while idle or in reset.
- SEED, 32'h1, LFSR seed; a value of 0 is replaced by 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE/DONE
- dut_reset  out  1  active-high reset to processor
- d_in  out  DATA_W  data word to processor
- alu_out  in  DATA_W  processor ALU result
- address  in  ADDR_W  processor address
- mw_en  in  1  processor memory-write enable
- status  in  STAT_W  processor status
- busy  out  1  run in progress (RST or DRIVE)
- done  out  1  run complete, held until next start
- vec_count  out  16  vectors issued in current run
- store_count  out  16  DRIVE cycles with mw_en=1, saturating at 16'hFFFF
- signature  out  32  MISR result

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE, dut_reset=1, d_in=INIT_DATA.
  - busy=0, done=0, vec_count=0, store_count=0, signature=0, LFSR=SEED.
- FSM states are IDLE, RST, DRIVE and DONE. All outputs are registered.
- IDLE or DONE with start=1 on an edge:
  - Next state is RST; busy=1, done=0, dut_reset=1, d_in=INIT_DATA.
  - signature, vec_count and store_count clear to 0; LFSR reloads SEED.
- start is ignored while busy=1.
- RST lasts exactly RESET_CYCLES clocks. On its last edge:
  - Next state is DRIVE, dut_reset=0.
  - LFSR advances and the new value is loaded into d_in; vec_count=1.
- LFSR (Galois, right shift): next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - From seed 1 the sequence is 80200003, C0300002, 60180001, ...
- d_in word (base behaviour): the LFSR value zero-extended to DATA_W, or truncated when DATA_W<32.
- DRIVE:
  - Each vector is held HOLD_CYCLES clocks, then the LFSR advances, the new word is loaded and vec_count increments.
  - After the NUM_VECTORS-th vector has been held, next state is DONE: busy=0, done=1.
  - d_in keeps its last word and dut_reset stays 0.
- Timing: done rises RESET_CYCLES + NUM_VECTORS*HOLD_CYCLES edges after the start-sampling edge (42 with defaults).
- MISR updates on every edge where state==DRIVE (NUM_VECTORS*HOLD_CYCLES updates per run):
  - fold = XOR of all 32-bit lanes of alu_out (zero-padded) ^ (address<<8) ^ status, each zero-extended to 32 bits.
  - sig_next = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold.
- store_count increments on a DRIVE edge when mw_en=1 and saturates at 16'hFFFF.
- Outside DRIVE, signature and counters hold their values.
- If reset is asserted mid-run, all state returns to reset values immediately; no partial signature is kept.

Optional Feature:
- Macro: PROC_STIM_WIDE_RANDOM_EN.
- Defined: when DATA_W is 32 or more, lane k (bits 32k+31:32k) = LFSR value rotated left by 7*k (mod 32). Every lane is populated.
- Undefined: upper lanes are 0 (zero-extended word).
- LFSR stepping and the MISR are identical in both builds.

Decomposition:
- Shared constants file proc_stim_pkg holds:
  - state encodings IDLE=0, RST=1, DRIVE=2, DONE=3;
  - LFSR_TAPS=32'h80200003;
  - MISR tap positions 31, 21, 1, 0.
- One natural sub-module: proc_stim_lfsr32 (seed load, advance enable, 32-bit state out).
- The MISR and lane folding stay inline in the top.

Test Plan:
- Power-on: reset=0 for 3 cycles, then 1, with no start -> dut_reset=1, d_in=10, busy=0, done=0, signature=0.
- Defaults, start pulse, alu_out/address/status/mw_en tied 0 -> d_in sequence 80200003, C0300002, 60180001 (each held 2 clocks); done at edge 42; vec_count=20; signature=0; store_count=0.
- NUM_VECTORS=1, HOLD_CYCLES=1, alu_out=1, others 0 -> exactly one MISR update; signature=32'h00000001; done 3 edges after start (RESET_CYCLES=2).
- mw_en=1 throughout DRIVE with defaults -> store_count=40. A pulse on start while busy -> no restart, done still at edge 42.
- reset=0 asserted during DRIVE vector 7 -> immediate IDLE, dut_reset=1, counters 0. A new start then reproduces the first-run d_in sequence from 80200003.
- With PROC_STIM_WIDE_RANDOM_EN, first vector -> d_in = {rotl(80200003,21), rotl(80200003,14), rotl(80200003,7), 80200003}.
